d_mem_arbiter: RTL and testbench
================================

Name: d_mem_arbiter

Overview:
- Two-requester controller that shares the single-port data memory (d_mem) between a CPU load/store port (r0) and a second master such as a DMA or debug port (r1).
- Arbitrates round-robin and range-checks the word address.
- Sequences the memory's strobe-based interface (write commits on the rising edge of MemWrite; ReadData is high-Z unless MemRead is high): address/data are set up one cycle before any strobe, and read data is captured into a register.
- Sits between the requesters and d_mem; it is the only driver of d_mem's inputs.

Parameters:
MEM_SIZE, 1024, number of 32-bit words in d_mem; valid word addresses are 0..MEM_SIZE-1
ADDR_W, 32, requester and memory address width (word address)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
r0_req  in  1  requester 0 access request; held with r0_we/r0_addr/r0_wdata stable until r0_ack
r0_we  in  1  1 = write, 0 = read
r0_addr  in  ADDR_W  word address
r0_wdata  in  32  write data
r0_ack  out  1  one-cycle completion pulse
r0_err  out  1  valid with r0_ack; 1 = address out of range, no access performed
r0_rdata  out  32  read data; valid from r0_ack of a read until the next r0 read ack
r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_err, r1_rdata  same as r0 for requester 1
mem_Address  out  32  to d_mem Address
mem_WriteData  out  32  to d_mem WriteData
mem_MemWrite  out  1  to d_mem MemWrite (registered, glitch-free)
mem_MemRead  out  1  to d_mem MemRead (registered)
mem_ReadData  in  32  from d_mem ReadData
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; all acks, errs, strobes, busy=0; mem_Address, mem_WriteData, r0_rdata, r1_rdata=0; rr_last=1, so r0 wins the first tie.
- FSM states: IDLE, SETUP, STROBE, DONE, ERR.
- IDLE:
  - If no req, stay.
  - If exactly one req, grant it.
  - If both req, grant the port != rr_last.
  - On grant, latch sel/we/addr/wdata and set rr_last=sel.
  - If latched addr >= MEM_SIZE, next=ERR; else next=SETUP.
- SETUP:
  - mem_Address and mem_WriteData (writes only) driven from the latch.
  - Both strobes 0. Next=STROBE.
- STROBE:
  - Write: mem_MemWrite=1 for exactly this cycle.
  - Read: mem_MemRead=1 for this cycle; mem_ReadData is sampled into sel's rdata at the clock edge ending STROBE.
  - Next=DONE.
- DONE:
  - Strobes 0; mem_Address/mem_WriteData still held (hold time).
  - sel's ack=1, err=0. Next=IDLE.
- ERR: sel's ack=1, err=1; no strobe asserted; rdata unchanged. Next=IDLE.
- Latency: an arbitration in cycle N gives ack in cycle N+3 (ERR: N+1). Minimum 4 cycles per access; at most one access in flight.
- mem_Address/mem_WriteData keep their last values in IDLE; they change only on a grant.
- Only the granted port's ack/err ever pulse; the other port's outputs stay 0/unchanged.
- A req still high in the IDLE cycle after its ack is a new request.
- Requester inputs are ignored after the grant latch; changes mid-transaction have no effect.
- Reset mid-operation:
  - Asserted in IDLE/SETUP: no memory write occurs.
  - Asserted during STROBE of a write: the write is already committed by the MemWrite rising edge; MemWrite drops asynchronously; no ack is issued.
- Starvation-free: with both ports continuously requesting, grants alternate r0,r1,r0,...
- Width: addr compared unsigned at full ADDR_W; mem_Address = latched addr zero-extended/truncated to 32.

Test Plan:
- Reset, then r0 writes 0xDEADBEEF to addr 5 -> mem_MemWrite high exactly one cycle with mem_Address=5 stable SETUP..DONE; r0_ack 3 cycles after grant, r0_err=0.
- r1 reads addr 5 -> mem_MemRead high one cycle; r1_rdata=0xDEADBEEF at r1_ack; r0_rdata unchanged.
- r0 and r1 request in the same cycle from reset, both holding req for 4 transactions -> grant order r0,r1,r0,r1; each ack 4 cycles apart.
- r0 reads addr 1024 (MEM_SIZE=1024) -> r0_ack and r0_err=1 one cycle after grant; mem_MemRead/mem_MemWrite never assert.
- Assert reset during SETUP of a write to addr 7 (prior value 0x0) -> no MemWrite edge, memory[7] stays 0x0, all outputs 0, busy=0, no ack.
- r1 changes r1_addr from 3 to 9 during SETUP of its read -> access targets addr 3; r1_rdata=memory[3].

Source files
------------

// File: rtl/d_mem_arbiter.sv
// Round-robin arbiter sharing the strobe-based d_mem between two requesters.
// Each access runs SETUP -> STROBE -> DONE (or ERR for out-of-range addresses).
module d_mem_arbiter #(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  output logic              r0_ack,
  output logic              r0_err,
  output logic [31:0]       r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  output logic              r1_ack,
  output logic              r1_err,
  output logic [31:0]       r1_rdata,
  output logic [31:0]       mem_Address,
  output logic [31:0]       mem_WriteData,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [31:0]       mem_ReadData,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  // Handshake: a requester raises req with we/addr/wdata and holds them until
  // its one-cycle ack; inputs are captured at the grant edge and ignored after.
  // A req still high in the IDLE cycle following its ack is a fresh request.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_SIZE);

  state_t            state;
  state_t            state_nxt;
  logic              rr_last;
  logic              sel_q;
  logic              we_q;

  logic              gnt;
  logic              gnt_sel;
  logic              gnt_we;
  logic              gnt_oor;
  logic [ADDR_W-1:0] gnt_addr;
  logic [31:0]       gnt_wdata;

  // Arbitration: a lone requester wins; on a tie the port not served last wins.
  always_comb begin
    gnt       = 1'b0;
    gnt_sel   = 1'b0;
    gnt_we    = 1'b0;
    gnt_oor   = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    if (state == IDLE && (r0_req || r1_req)) begin
      gnt = 1'b1;
      if (r0_req && r1_req) begin
        gnt_sel = ~rr_last;
      end else begin
        gnt_sel = r1_req;
      end
    end
    gnt_we    = gnt_sel ? r1_we    : r0_we;
    gnt_addr  = gnt_sel ? r1_addr  : r0_addr;
    gnt_wdata = gnt_sel ? r1_wdata : r0_wdata;
    gnt_oor   = (gnt_addr >= ADDR_LIMIT);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt) begin
          state_nxt = gnt_oor ? ERR : SETUP;
        end
      end
      SETUP:  state_nxt = STROBE;
      STROBE: state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      ERR:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes are flops so d_mem sees clean edges; address/data are loaded at the
  // grant edge, one full cycle ahead of the strobe, and held through DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last       <= 1'b1;
      sel_q         <= 1'b0;
      we_q          <= 1'b0;
      mem_Address   <= '0;
      mem_WriteData <= '0;
      mem_MemWrite  <= 1'b0;
      mem_MemRead   <= 1'b0;
      r0_rdata      <= '0;
      r1_rdata      <= '0;
    end else begin
      mem_MemWrite <= (state == SETUP) &&  we_q;
      mem_MemRead  <= (state == SETUP) && !we_q;
      if (gnt) begin
        sel_q   <= gnt_sel;
        we_q    <= gnt_we;
        rr_last <= gnt_sel;
        if (!gnt_oor) begin
          mem_Address <= 32'(gnt_addr);
          if (gnt_we) begin
            mem_WriteData <= gnt_wdata;
          end
        end
      end
      if (state == STROBE && !we_q) begin
        if (sel_q) begin
          r1_rdata <= mem_ReadData;
        end else begin
          r0_rdata <= mem_ReadData;
        end
      end
    end
  end

  assign r0_ack    = ((state == DONE) || (state == ERR)) && !sel_q;
  assign r1_ack    = ((state == DONE) || (state == ERR)) &&  sel_q;
  assign r0_err    = (state == ERR) && !sel_q;
  assign r1_err    = (state == ERR) &&  sel_q;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Randomized bench for d_mem_arbiter: transaction-level model of grants,
// latencies and memory contents, plus a strobe scoreboard on the d_mem side.
module tb_d_mem_arbiter;

  localparam int MEM_SIZE = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0_req = 1'b0, r0_we = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0;
  logic        r0_ack, r0_err;
  logic [31:0] r0_rdata;
  logic        r1_req = 1'b0, r1_we = 1'b0;
  logic [31:0] r1_addr = '0, r1_wdata = '0;
  logic        r1_ack, r1_err;
  logic [31:0] r1_rdata;
  logic [31:0] mem_Address, mem_WriteData, mem_ReadData;
  logic        mem_MemWrite, mem_MemRead;
  logic        busy;
  logic [2:0]  dbg_state;

  logic [31:0] dmem      [0:MEM_SIZE-1];
  logic [31:0] model_mem [0:MEM_SIZE-1];
  logic [31:0] exp_rdata [2];
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  int          last_served;
  bit          in_txn = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  d_mem_arbiter #(.MEM_SIZE(MEM_SIZE), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_Address(mem_Address), .mem_WriteData(mem_WriteData),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
    .mem_ReadData(mem_ReadData), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // d_mem model: write commits on MemWrite rising edge; floating bus reads as a marker.
  always @(posedge mem_MemWrite) begin
    if (mem_Address < MEM_SIZE) dmem[mem_Address[9:0]] <= mem_WriteData;
  end
  assign mem_ReadData = mem_MemRead ? dmem[mem_Address[9:0]] : 32'hBAD0_BAD0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply_reset();
    reset  = 1'b1;
    r0_req = 1'b0;
    r1_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last_served  = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    exp_q.delete();
  endtask

  function automatic int lat(input logic [31:0] a);
    return (a < MEM_SIZE) ? 3 : 1;
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 7))
      5:       return 32'd1023;
      6:       return 32'd1024;
      7:       return $urandom | 32'h8000_0000;
      default: return 32'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic push_expect(input bit we, input logic [31:0] a, input logic [31:0] d);
    if (a < MEM_SIZE) exp_q.push_back({we, a, d});
  endtask

  // ---------------- scoreboard on the memory side ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_MemWrite || mem_MemRead) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_strobe", 32'({mem_MemWrite, mem_MemRead}), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("strobe_kind", 32'({mem_MemWrite, mem_MemRead}), mon_e[64] ? 32'd2 : 32'd1);
          check_eq("strobe_addr", mem_Address, mon_e[63:32]);
          if (mon_e[64]) check_eq("strobe_wdata", mem_WriteData, mon_e[31:0]);
        end
      end
      if (!in_txn) check_eq("stray_ack", 32'({r0_ack, r1_ack}), 32'd0);
    end
  end

  // Checks made at an ack, then the model is advanced.
  task automatic check_ack(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
    bit inr;
    inr = (a < MEM_SIZE);
    check_eq("ack_err", 32'(p == 1 ? r1_err : r0_err), 32'(!inr));
    if (inr && !we) exp_rdata[p] = model_mem[a[9:0]];
    if (inr && we)  model_mem[a[9:0]] = d;
    check_eq("rdata0", r0_rdata, exp_rdata[0]);
    check_eq("rdata1", r1_rdata, exp_rdata[1]);
    if (inr) check_eq("hold_addr", mem_Address, a);
    check_eq("busy_ack", 32'(busy), 32'd1);
  endtask

  // ---------------- driver ----------------
  task automatic run_txn(input bit act0, input bit act1, input bit we0, input bit we1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1, input bit mutate);
    bit          we[2];
    logic [31:0] a[2];
    logic [31:0] d[2];
    int          first, cur, k, exp_k, done_cnt, ntxn;
    we[0] = we0; we[1] = we1; a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    ntxn = int'(act0) + int'(act1);
    if (ntxn == 0) return;
    first = (act0 && act1) ? ((last_served == 0) ? 1 : 0) : (act0 ? 0 : 1);
    cur = first;
    in_txn = 1'b1;
    push_expect(we[cur], a[cur], d[cur]);
    @(negedge clk);
    r0_req = act0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_req = act1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
    exp_k = lat(a[cur]);
    k = 0;
    done_cnt = 0;
    while (done_cnt < ntxn && k < 40) begin
      @(negedge clk);
      k++;
      if (mutate && k == 1) begin
        if (first == 0) begin r0_addr = a0 ^ 32'hA; r0_wdata = ~d0; end
        else            begin r1_addr = a1 ^ 32'hA; r1_wdata = ~d1; end
      end
      if (lat(a[cur]) == 3 && k >= exp_k - 2 && k <= exp_k)
        check_eq("addr_stable", mem_Address, a[cur]);
      if (r0_ack || r1_ack) begin
        check_eq("ack_port", 32'({r1_ack, r0_ack}), (cur == 0) ? 32'd1 : 32'd2);
        check_eq("ack_cycle", 32'(k), 32'(exp_k));
        check_ack(cur, we[cur], a[cur], d[cur]);
        if (cur == 0) r0_req = 1'b0; else r1_req = 1'b0;
        last_served = cur;
        done_cnt++;
        if (done_cnt < ntxn) begin
          cur = 1 - cur;
          push_expect(we[cur], a[cur], d[cur]);
          exp_k = k + 1 + lat(a[cur]);
        end
      end
    end
    if (done_cnt < ntxn) check_eq("ack_timeout", 32'(done_cnt), 32'(ntxn));
    r0_req = 1'b0;
    r1_req = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("q_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    in_txn = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k, cnt, p;
    for (int i = 0; i < MEM_SIZE; i++) begin
      dmem[i] = '0;
      model_mem[i] = '0;
    end
    apply_reset();
    check_eq("rst_busy",   32'(busy), 32'd0);
    check_eq("rst_acks",   32'({r0_ack, r1_ack, r0_err, r1_err}), 32'd0);
    check_eq("rst_strobe", 32'({mem_MemWrite, mem_MemRead}), 32'd0);
    check_eq("rst_addr",   mem_Address, 32'd0);
    check_eq("rst_wdata",  mem_WriteData, 32'd0);
    check_eq("rst_rdata0", r0_rdata, 32'd0);
    check_eq("rst_rdata1", r1_rdata, 32'd0);

    run_txn(1, 0, 1, 0, 32'd5, 32'd0, 32'hDEAD_BEEF, 32'd0, 0);
    run_txn(0, 1, 0, 0, 32'd0, 32'd5, 32'd0, 32'd0, 0);
    run_txn(1, 0, 0, 0, 32'd1024, 32'd0, 32'd0, 32'd0, 0);

    // reset during SETUP of a write: nothing may reach memory, no ack
    @(negedge clk);
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd7; r0_wdata = 32'hCAFE_0007;
    @(negedge clk);
    check_eq("setup_addr", mem_Address, 32'd7);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_busy",   32'(busy), 32'd0);
    check_eq("arst_acks",   32'({r0_ack, r1_ack, r0_err, r1_err}), 32'd0);
    check_eq("arst_strobe", 32'({mem_MemWrite, mem_MemRead}), 32'd0);
    check_eq("arst_addr",   mem_Address, 32'd0);
    check_eq("arst_wdata",  mem_WriteData, 32'd0);
    check_eq("arst_rdata",  r0_rdata | r1_rdata, 32'd0);
    r0_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_served  = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    repeat (3) @(negedge clk);
    check_eq("mem7_kept", dmem[7], 32'd0);
    run_txn(1, 0, 0, 0, 32'd7, 32'd0, 32'd0, 32'd0, 0);

    // both ports requesting continuously from reset: r0,r1,r0,r1, 4 cycles apart
    apply_reset();
    in_txn = 1'b1;
    for (int i = 0; i < 4; i++) push_expect(i % 2 == 0, 32'd10, 32'h1234_5678);
    @(negedge clk);
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd10; r0_wdata = 32'h1234_5678;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'd10; r1_wdata = 32'h0;
    k = 0;
    cnt = 0;
    while (cnt < 4 && k < 40) begin
      @(negedge clk);
      k++;
      if (r0_ack || r1_ack) begin
        p = cnt % 2;
        check_eq("rr_port", 32'({r1_ack, r0_ack}), (p == 0) ? 32'd1 : 32'd2);
        check_eq("rr_cycle", 32'(k), 32'(3 + 4 * cnt));
        check_ack(p, p == 0, 32'd10, 32'h1234_5678);
        last_served = p;
        cnt++;
        if (cnt == 4) begin r0_req = 1'b0; r1_req = 1'b0; end
      end
    end
    if (cnt < 4) check_eq("rr_timeout", 32'(cnt), 32'd4);
    r0_req = 1'b0;
    r1_req = 1'b0;
    @(negedge clk);
    check_eq("rr_idle", 32'(busy), 32'd0);
    exp_q.delete();
    in_txn = 1'b0;

    // inputs changed after the grant must not redirect the access
    run_txn(1, 0, 1, 0, 32'd3, 32'd0, 32'h3333_3333, 32'd0, 0);
    run_txn(1, 0, 1, 0, 32'd9, 32'd0, 32'h9999_9999, 32'd0, 0);
    run_txn(0, 1, 0, 0, 32'd0, 32'd3, 32'd0, 32'd0, 1);

    for (int i = 0; i < 80; i++) begin
      bit act0, act1;
      act0 = 1'($urandom_range(0, 1));
      act1 = 1'($urandom_range(0, 1));
      if (!act0 && !act1) act0 = 1'b1;
      run_txn(act0, act1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              pick_addr(), pick_addr(), $urandom, $urandom, 1'($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
